// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response channels of the two ALU requesters
interface alu_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);
  logic                     req0_valid;
  logic                     req0_ready;
  logic [DATA_WIDTH-1:0]    req0_src_a;
  logic [DATA_WIDTH-1:0]    req0_src_b;
  logic [OPCODE_LENGTH-1:0] req0_op;
  logic                     req1_valid;
  logic                     req1_ready;
  logic [DATA_WIDTH-1:0]    req1_src_a;
  logic [DATA_WIDTH-1:0]    req1_src_b;
  logic [OPCODE_LENGTH-1:0] req1_op;
  logic                     resp0_valid;
  logic                     resp0_ready;
  logic [DATA_WIDTH-1:0]    resp0_data;
  logic                     resp1_valid;
  logic                     resp1_ready;
  logic [DATA_WIDTH-1:0]    resp1_data;

  modport master (
    output req0_valid, req0_src_a, req0_src_b, req0_op,
    output req1_valid, req1_src_a, req1_src_b, req1_op,
    output resp0_ready, resp1_ready,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_data, resp1_valid, resp1_data
  );

  modport slave (
    input  req0_valid, req0_src_a, req0_src_b, req0_op,
    input  req1_valid, req1_src_a, req1_src_b, req1_op,
    input  resp0_ready, resp1_ready,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_data, resp1_valid, resp1_data
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
// Optional grant counters enabled by ALU_ARB_STATS_EN.
module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_arbiter_if.slave             bus,
  output logic [DATA_WIDTH-1:0]    alu_src_a,
  output logic [DATA_WIDTH-1:0]    alu_src_b,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  output logic [CNT_WIDTH-1:0]     grant_cnt0,
  output logic [CNT_WIDTH-1:0]     grant_cnt1
);
  logic                  rr_ptr;
  logic                  elig0, elig1;
  logic                  grant0, grant1;
  logic                  resp0_valid_q, resp1_valid_q;
  logic [DATA_WIDTH-1:0] resp0_data_q, resp1_data_q;

  // A requester is eligible only if its result slot is free or being drained now.
  assign elig0 = rst_n & bus.req0_valid & (~resp0_valid_q | bus.resp0_ready);
  assign elig1 = rst_n & bus.req1_valid & (~resp1_valid_q | bus.resp1_ready);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (elig0 && elig1) begin
      grant0 = ~rr_ptr;
      grant1 = rr_ptr;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  always_comb begin
    alu_src_a = '0;
    alu_src_b = '0;
    alu_op    = '0;
    if (grant0) begin
      alu_src_a = bus.req0_src_a;
      alu_src_b = bus.req0_src_b;
      alu_op    = bus.req0_op;
    end else if (grant1) begin
      alu_src_a = bus.req1_src_a;
      alu_src_b = bus.req1_src_b;
      alu_op    = bus.req1_op;
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.resp0_valid = resp0_valid_q;
  assign bus.resp1_valid = resp1_valid_q;
  assign bus.resp0_data  = resp0_data_q;
  assign bus.resp1_data  = resp1_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr        <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_data_q  <= '0;
      resp1_data_q  <= '0;
    end else begin
      if (grant0)      rr_ptr <= 1'b1;
      else if (grant1) rr_ptr <= 1'b0;

      // A grant in the same cycle as a drain keeps the slot full with the new result.
      if (grant0) begin
        resp0_valid_q <= 1'b1;
        resp0_data_q  <= alu_result;
      end else if (bus.resp0_ready) begin
        resp0_valid_q <= 1'b0;
      end

      if (grant1) begin
        resp1_valid_q <= 1'b1;
        resp1_data_q  <= alu_result;
      end else if (bus.resp1_ready) begin
        resp1_valid_q <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] cnt0, cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (grant0 && cnt0 != '1) cnt0 <= cnt0 + CNT_WIDTH'(1);
      if (grant1 && cnt1 != '1) cnt1 <= cnt1 + CNT_WIDTH'(1);
    end
  end

  assign grant_cnt0 = cnt0;
  assign grant_cnt1 = cnt1;
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int OL = 4;
  localparam int CW = 2;

  localparam logic [OL-1:0] OP_AND = 4'b0000;
  localparam logic [OL-1:0] OP_ADD = 4'b0010;
  localparam logic [OL-1:0] OP_SUB = 4'b0110;

`ifdef ALU_ARB_STATS_EN
  localparam logic [CW-1:0] EXP_CNT0_MID = 2'd3;
  localparam logic [CW-1:0] EXP_CNT0     = 2'd3;
  localparam logic [CW-1:0] EXP_CNT1     = 2'd2;
`else
  localparam logic [CW-1:0] EXP_CNT0_MID = 2'd0;
  localparam logic [CW-1:0] EXP_CNT0     = 2'd0;
  localparam logic [CW-1:0] EXP_CNT1     = 2'd0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] alu_src_a, alu_src_b, alu_result;
  logic [OL-1:0] alu_op;
  logic [CW-1:0] grant_cnt0, grant_cnt1;
  int            tests = 0;
  int            failed = 0;

  alu_arbiter_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL)) bus ();

  alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .alu_result(alu_result), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  always #5 clk = ~clk;

  // Reference ALU; unknown opcodes return 0.
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_src_a & alu_src_b;
      4'b0001: alu_result = alu_src_a | alu_src_b;
      4'b0010: alu_result = alu_src_a + alu_src_b;
      4'b0110: alu_result = alu_src_a - alu_src_b;
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic set_req0(input logic v, input logic [OL-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.req0_valid = v; bus.req0_op = op; bus.req0_src_a = a; bus.req0_src_b = b;
  endtask

  task automatic set_req1(input logic v, input logic [OL-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.req1_valid = v; bus.req1_op = op; bus.req1_src_a = a; bus.req1_src_b = b;
  endtask

  initial begin
    rst_n = 1'b0;
    set_req0(1'b1, OP_ADD, 32'd1, 32'd1);
    set_req1(1'b0, OP_AND, '0, '0);
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    #1;
    check("rst_resp0_valid", bus.resp0_valid, 0);
    check("rst_resp0_data", bus.resp0_data, 0);
    check("rst_req0_ready", bus.req0_ready, 0);
    check("rst_alu_src_a", alu_src_a, 0);
    check("rst_alu_op", alu_op, 0);
    tick();
    check("rst_held_resp0_valid", bus.resp0_valid, 0);
    #3;
    rst_n = 1'b1;
    set_req0(1'b0, OP_AND, '0, '0);
    tick();

    // 1: single requester ADD
    set_req0(1'b1, OP_ADD, 32'd5, 32'd7);
    #1;
    check("t1_req0_ready", bus.req0_ready, 1);
    check("t1_alu_src_a", alu_src_a, 5);
    check("t1_alu_op", alu_op, OP_ADD);
    tick();
    set_req0(1'b0, OP_AND, '0, '0);
    check("t1_resp0_valid", bus.resp0_valid, 1);
    check("t1_resp0_data", bus.resp0_data, 12);
    #1;
    check("t1_idle_alu_src_a", alu_src_a, 0);
    tick();
    check("t1_drained", bus.resp0_valid, 0);
    check("t1_data_held", bus.resp0_data, 12);

    // 2: simultaneous requests after reset
    do_reset();
    set_req0(1'b1, OP_AND, 32'h0000F0F0, 32'h0000FF00);
    set_req1(1'b1, OP_SUB, 32'd10, 32'd3);
    #1;
    check("t2_c0_req0_ready", bus.req0_ready, 1);
    check("t2_c0_req1_ready", bus.req1_ready, 0);
    tick();
    set_req0(1'b0, OP_AND, '0, '0);
    check("t2_resp0_data", bus.resp0_data, 32'h0000F000);
    #1;
    check("t2_c1_req1_ready", bus.req1_ready, 1);
    check("t2_c1_alu_op", alu_op, OP_SUB);
    tick();
    set_req1(1'b0, OP_AND, '0, '0);
    check("t2_resp1_valid", bus.resp1_valid, 1);
    check("t2_resp1_data", bus.resp1_data, 7);
    check("t2_resp0_drained", bus.resp0_valid, 0);

    // 3: continuous contention alternates grants
    set_req0(1'b1, OP_ADD, 32'd1, 32'd100);
    set_req1(1'b1, OP_ADD, 32'd2, 32'd200);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t3_req0_ready_%0d", i), bus.req0_ready, (i % 2 == 0) ? 1 : 0);
      check($sformatf("t3_req1_ready_%0d", i), bus.req1_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      if (i % 2 == 0) begin
        check($sformatf("t3_resp0_valid_%0d", i), bus.resp0_valid, 1);
        check($sformatf("t3_resp0_data_%0d", i), bus.resp0_data, 101);
        check($sformatf("t3_resp1_valid_%0d", i), bus.resp1_valid, 0);
      end else begin
        check($sformatf("t3_resp1_valid_%0d", i), bus.resp1_valid, 1);
        check($sformatf("t3_resp1_data_%0d", i), bus.resp1_data, 202);
        check($sformatf("t3_resp0_valid_%0d", i), bus.resp0_valid, 0);
      end
    end
    set_req0(1'b0, OP_AND, '0, '0);
    set_req1(1'b0, OP_AND, '0, '0);
    tick();

    // 4: blocked requester, then drain and grant in the same cycle
    bus.resp0_ready = 1'b0;
    set_req0(1'b1, OP_ADD, 32'd3, 32'd4);
    tick();
    check("t4_resp0_data_first", bus.resp0_data, 7);
    set_req0(1'b1, OP_ADD, 32'd10, 32'd20);
    set_req1(1'b1, OP_ADD, 32'd1, 32'd1);
    #1;
    check("t4_req0_blocked", bus.req0_ready, 0);
    check("t4_req1_granted", bus.req1_ready, 1);
    tick();
    set_req1(1'b0, OP_AND, '0, '0);
    check("t4_resp1_data", bus.resp1_data, 2);
    check("t4_resp0_still_valid", bus.resp0_valid, 1);
    bus.resp0_ready = 1'b1;
    #1;
    check("t4_req0_granted", bus.req0_ready, 1);
    tick();
    set_req0(1'b0, OP_AND, '0, '0);
    check("t4_resp0_valid_kept", bus.resp0_valid, 1);
    check("t4_resp0_new_data", bus.resp0_data, 30);

    // 5: async reset with a pending result; rr_ptr left pointing at req1 first
    bus.resp1_ready = 1'b0;
    set_req1(1'b1, OP_ADD, 32'd8, 32'd9);
    tick();
    set_req1(1'b0, OP_AND, '0, '0);
    set_req0(1'b1, OP_ADD, 32'd1, 32'd2);
    tick();
    set_req0(1'b0, OP_AND, '0, '0);
    check("t5_resp1_valid_pre", bus.resp1_valid, 1);
    check("t5_resp1_data_pre", bus.resp1_data, 17);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_resp1_valid_rst", bus.resp1_valid, 0);
    check("t5_resp1_data_rst", bus.resp1_data, 0);
    check("t5_resp0_data_rst", bus.resp0_data, 0);
    tick();
    #3;
    rst_n = 1'b1;
    bus.resp1_ready = 1'b1;
    set_req0(1'b1, OP_ADD, 32'd1, 32'd1);
    set_req1(1'b1, OP_ADD, 32'd2, 32'd2);
    #1;
    check("t5_req0_first", bus.req0_ready, 1);
    check("t5_req1_wait", bus.req1_ready, 0);
    set_req0(1'b0, OP_AND, '0, '0);
    set_req1(1'b0, OP_AND, '0, '0);

    // 6: grant counters and saturation
    do_reset();
    check("t6_cnt0_rst", grant_cnt0, 0);
    set_req1(1'b1, OP_ADD, 32'd0, 32'd0);
    tick();
    tick();
    set_req1(1'b0, OP_AND, '0, '0);
    set_req0(1'b1, OP_ADD, 32'd0, 32'd0);
    tick();
    tick();
    tick();
    check("t6_cnt0_at_max", grant_cnt0, EXP_CNT0_MID);
    tick();
    tick();
    set_req0(1'b0, OP_AND, '0, '0);
    check("t6_cnt0_saturated", grant_cnt0, EXP_CNT0);
    check("t6_cnt1", grant_cnt1, EXP_CNT1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU between two requesters, e.g. the integer pipe and a multi-cycle address/branch helper.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Fair round-robin grant; at most one ALU operation per cycle.
- ALU result is registered per requester, so request-to-response latency is 1 cycle.

Parameters:
DATA_WIDTH, 32, operand/result width (matches ALU)
OPCODE_LENGTH, 4, ALU operation code width
CNT_WIDTH, 16, width of grant statistics counters (used only with the optional feature)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 granted this cycle
req0_src_a  input  DATA_WIDTH  requester 0 operand A
req0_src_b  input  DATA_WIDTH  requester 0 operand B
req0_op  input  OPCODE_LENGTH  requester 0 ALU operation code
req1_valid/req1_ready/req1_src_a/req1_src_b/req1_op  same as requester 0, for requester 1
resp0_valid  output  1  result pending for requester 0
resp0_ready  input  1  requester 0 accepts result
resp0_data  output  DATA_WIDTH  registered ALU result for requester 0
resp1_valid/resp1_ready/resp1_data  same as requester 0, for requester 1
alu_src_a  output  DATA_WIDTH  to ALU SrcA
alu_src_b  output  DATA_WIDTH  to ALU SrcB
alu_op  output  OPCODE_LENGTH  to ALU Operation
alu_result  input  DATA_WIDTH  from ALU ALUResult
grant_cnt0  output  CNT_WIDTH  grants to requester 0 (optional feature)
grant_cnt1  output  CNT_WIDTH  grants to requester 1 (optional feature)

Behaviour:
- Reset (rst_n low, async): resp*_valid=0, resp*_data=0, rr_ptr=0, counters=0. While rst_n is low, req*_ready=0 and alu_* outputs=0.
- Eligibility: elig_i = reqi_valid & (~respi_valid | respi_ready). A requester is never granted while its unaccepted result would be overwritten.
- Grant (combinational, one-hot or none):
  - One eligible requester: grant it.
  - Both eligible: grant requester rr_ptr.
  - req*_ready equals grant_i.
- rr_ptr update: after a grant to i, rr_ptr <= ~i. No grant leaves rr_ptr unchanged.
- ALU drive:
  - On a grant: alu_src_a/alu_src_b/alu_op = granted requester's operands/op, combinationally.
  - No grant: alu_src_a=0, alu_src_b=0, alu_op=4'b0000.
- Result capture: on a grant to i, respi_data <= alu_result and respi_valid <= 1 at the next edge.
  - Opcode is passed through unchecked; undefined codes return 0 from the ALU.
- Response drain: respi_valid & respi_ready with no new grant to i clears respi_valid at the next edge. respi_data holds its last value.
- Simultaneous drain and grant to the same i: respi_valid stays 1 and respi_data takes the new result. This gives back-to-back throughput of 1 op/cycle per requester.
- Requesters hold valid and operands stable until ready. The arbiter does not register requests.
- Requester i is blocked while respi_valid=1 and respi_ready=0. The other requester may still be granted.
- Reset mid-operation: pending results are discarded and nothing is replayed.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
  - Defined: grant_cnt0/grant_cnt1 increment by 1 on each grant to that requester. They saturate at 2^CNT_WIDTH-1 (no wrap) and clear on reset.
  - Undefined: no counter registers; grant_cnt0/grant_cnt1 are driven constant 0.

Test Plan:
1. Only req0_valid, op=0010 (ADD), A=5, B=7 -> req0_ready=1 that cycle, alu_src_a=5; next cycle resp0_valid=1, resp0_data=12.
2. After reset, both valid the same cycle: req0 AND 0xF0F0 & 0xFF00, req1 SUB 10-3 -> cycle0 grants req0; cycle1 resp0_data=0x0000F000 and req1 granted; cycle2 resp1_data=7.
3. Both valid continuously with resp*_ready=1 -> grants alternate 0,1,0,1; responses arrive one per cycle in the same order.
4. resp0_valid=1, resp0_ready=0, req0 and req1 valid -> req0_ready=0, req1 granted. Raise resp0_ready -> req0 granted that same cycle, resp0_valid stays 1, resp0_data becomes the new result.
5. Pull rst_n low asynchronously while resp1_valid=1 -> resp1_valid=0 and resp1_data=0 immediately. After release with both valid, req0 is granted first.
6. With ALU_ARB_STATS_EN, CNT_WIDTH=2: 5 grants to req0 and 2 to req1 -> grant_cnt0=3 (saturated), grant_cnt1=2. Without the macro -> both read 0.
